// File: rtl/keypad_scanner.sv
// 3x3 active-low keypad scanner: column scan, frame-based debounce and a
// one-shot write per clean press/release of a single key.
module keypad_scanner #(
  parameter int SCAN_CYCLES    = 16,
  parameter int DEBOUNCE_COUNT = 4
) (
  input  logic       ph1,
  input  logic       reset,
  input  logic [2:0] row,
  output logic [2:0] col,
  input  logic       gameIsDone,
  output logic       playerWrite,
  output logic [3:0] playerInput,
  output logic       keyHeld,
  output logic [1:0] o_dbg_state
);

  localparam int CW = $clog2(SCAN_CYCLES);
  localparam int SW = $clog2(DEBOUNCE_COUNT + 1);
  localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_CYCLES - 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_COUNT);
  localparam logic [3:0]    CODE_NONE  = 4'hE;
  localparam logic [3:0]    CODE_MULTI = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READY = 2'd1,
    S_HELD  = 2'd2
  } state_t;

  logic [2:0]    r_sync1, r_sync2;
  logic [CW-1:0] r_scan_cnt;
  logic [1:0]    r_col_idx;
  logic [8:0]    r_frame;
  logic          r_frame_done;
  logic [3:0]    r_prev_code;
  logic [SW-1:0] r_stable_cnt;
  state_t        r_state;
  logic          r_write;
  logic [3:0]    r_input;

  logic [3:0]    w_ones;
  logic [3:0]    w_code;
  logic [3:0]    w_single;
  logic [SW-1:0] w_cnt_next;
  logic          w_stable;
  state_t        w_state_next;
  logic          w_fire;

  // Scanner: rows are captured on the last cycle of each column window.
  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      r_sync1      <= 3'b111;
      r_sync2      <= 3'b111;
      r_scan_cnt   <= '0;
      r_col_idx    <= 2'd0;
      r_frame      <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_sync1      <= row;
      r_sync2      <= r_sync1;
      r_frame_done <= 1'b0;
      if (r_scan_cnt == SCAN_LAST) begin
        r_scan_cnt <= '0;
        case (r_col_idx)
          2'd0:    {r_frame[6], r_frame[3], r_frame[0]} <= ~r_sync2;
          2'd1:    {r_frame[7], r_frame[4], r_frame[1]} <= ~r_sync2;
          default: {r_frame[8], r_frame[5], r_frame[2]} <= ~r_sync2;
        endcase
        if (r_col_idx == 2'd2) begin
          r_col_idx    <= 2'd0;
          r_frame_done <= 1'b1;
        end else begin
          r_col_idx <= r_col_idx + 2'd1;
        end
      end else begin
        r_scan_cnt <= r_scan_cnt + CW'(1);
      end
    end
  end

  assign col = ~(3'b001 << r_col_idx);

  always_comb begin
    w_ones   = 4'd0;
    w_single = 4'd0;
    for (int i = 0; i < 9; i++) begin
      w_ones = w_ones + {3'b000, r_frame[i]};
      if (r_frame[i]) w_single = 4'(i);
    end
    if (w_ones == 4'd0)      w_code = CODE_NONE;
    else if (w_ones == 4'd1) w_code = w_single;
    else                     w_code = CODE_MULTI;
  end

  // Run length of identical frame codes, saturating so it never wraps.
  always_comb begin
    w_cnt_next = SW'(1);
    if (w_code == r_prev_code) begin
      if (r_stable_cnt == STABLE_MAX) w_cnt_next = r_stable_cnt;
      else                            w_cnt_next = r_stable_cnt + SW'(1);
    end
    w_stable = (w_cnt_next == STABLE_MAX);
  end

  always_comb begin
    w_state_next = r_state;
    w_fire       = 1'b0;
    if (r_frame_done && w_stable) begin
      case (r_state)
        S_IDLE:  if (w_code == CODE_NONE) w_state_next = S_READY;
        S_READY: if (w_code != CODE_NONE) begin
                   w_state_next = S_HELD;
                   w_fire       = (w_code != CODE_MULTI) && !gameIsDone;
                 end
        S_HELD:  if (w_code == CODE_NONE) w_state_next = S_READY;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      r_prev_code  <= CODE_NONE;
      r_stable_cnt <= '0;
      r_state      <= S_IDLE;
      r_write      <= 1'b0;
      r_input      <= 4'd0;
    end else begin
      if (r_frame_done) begin
        r_prev_code  <= w_code;
        r_stable_cnt <= w_cnt_next;
      end
      r_state <= w_state_next;
      r_write <= w_fire;
      if (w_fire) r_input <= w_code;
    end
  end

  assign playerWrite = r_write;
  assign playerInput = r_input;
  assign keyHeld     = (r_state == S_HELD);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomized bench for keypad_scanner: a frame-level keypad model predicts
// every write, the held flag and the column drive cycle by cycle.
module tb_keypad_scanner;

  localparam int SCAN  = 16;
  localparam int DEB   = 4;
  localparam int FRAME = 3 * SCAN;

  logic       ph1 = 1'b0;
  logic       reset;
  logic [2:0] row;
  logic [2:0] col;
  logic       game_done;
  logic       player_write;
  logic [3:0] player_input;
  logic       key_held;
  logic [1:0] dbg_state;

  logic [8:0] pressed;
  logic [8:0] cur_mask;
  logic       cur_gd;

  int n_checks = 0;
  int n_errors = 0;
  int n = 0;

  logic [3:0] hist_q[$];
  logic       m_armed, m_locked;
  logic       exp_write;
  logic [3:0] exp_input;

  keypad_scanner #(.SCAN_CYCLES(SCAN), .DEBOUNCE_COUNT(DEB)) dut (
    .ph1         (ph1),
    .reset       (reset),
    .row         (row),
    .col         (col),
    .gameIsDone  (game_done),
    .playerWrite (player_write),
    .playerInput (player_input),
    .keyHeld     (key_held),
    .o_dbg_state (dbg_state)
  );

  always #5 ph1 = ~ph1;

  // Physical keypad: a pressed key pulls its row low while its column is driven.
  always_comb begin
    row = 3'b111;
    for (int r = 0; r < 3; r++)
      row[r] = ~|(pressed[r*3 +: 3] & ~col);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, n);
    end
  endtask

  function automatic logic [3:0] frame_code(input logic [8:0] m);
    logic [3:0] k;
    k = 4'd0;
    for (int i = 0; i < 9; i++) if (m[i]) k = 4'(i);
    if (m == 9'd0)            return 4'hE;
    else if ($countones(m) == 1) return k;
    else                      return 4'hF;
  endfunction

  task automatic model_reset();
    hist_q.delete();
    m_armed   = 1'b0;
    m_locked  = 1'b0;
    exp_write = 1'b0;
    exp_input = 4'd0;
  endtask

  // One completed frame: stable means the last DEB frame codes since reset agree.
  task automatic model_frame(input logic [8:0] m, input logic gd);
    logic [3:0] code;
    logic       stable;
    code = frame_code(m);
    hist_q.push_back(code);
    if (hist_q.size() > DEB) void'(hist_q.pop_front());
    stable = (hist_q.size() == DEB);
    foreach (hist_q[i]) if (hist_q[i] != code) stable = 1'b0;
    if (!stable) return;
    if (code == 4'hE) begin
      m_armed  = 1'b1;
      m_locked = 1'b0;
    end else if (m_armed && !m_locked) begin
      m_locked = 1'b1;
      if (code != 4'hF && !gd) begin
        exp_write = 1'b1;
        exp_input = code;
      end
    end
  endtask

  task automatic step();
    logic [2:0] one;
    logic [2:0] exp_col;
    @(posedge ph1);
    n++;
    exp_write = 1'b0;
    if (n > 1 && (n % FRAME) == 1) model_frame(cur_mask, cur_gd);
    @(negedge ph1);
    one = 3'b001;
    exp_col = ~(one << ((n / SCAN) % 3));
    check_eq("col", 32'(col), 32'(exp_col));
    check_eq("playerWrite", 32'(player_write), 32'(exp_write));
    check_eq("playerInput", 32'(player_input), 32'(exp_input));
    check_eq("keyHeld", 32'(key_held), 32'(m_locked));
  endtask

  // One scan frame with a fixed key mask; gameIsDone may glitch mid-frame.
  task automatic run_frame(input logic [8:0] mask, input logic gd, input logic glitch);
    pressed   = mask;
    cur_mask  = mask;
    cur_gd    = gd;
    game_done = gd;
    for (int i = 0; i < FRAME; i++) begin
      if (glitch && i == 10) game_done = ~gd;
      if (i == 30) game_done = gd;
      step();
    end
  endtask

  task automatic hold(input logic [8:0] mask, input logic gd, input int frames);
    for (int f = 0; f < frames; f++) run_frame(mask, gd, 1'b0);
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b0;
    #1;
    check_eq("rst_col", 32'(col), 32'h6);
    check_eq("rst_write", 32'(player_write), 32'h0);
    check_eq("rst_input", 32'(player_input), 32'h0);
    check_eq("rst_held", 32'(key_held), 32'h0);
    model_reset();
    repeat (3) @(negedge ph1);
    reset = 1'b1;
    n = 0;
    cur_mask = pressed;
    step();
  endtask

  initial begin
    logic [8:0] m;
    logic       gd;
    int         sel;
    reset     = 1'b1;
    pressed   = 9'd0;
    cur_mask  = 9'd0;
    cur_gd    = 1'b0;
    game_done = 1'b0;
    model_reset();
    @(negedge ph1);
    do_reset();

    hold(9'd0, 1'b0, 6);
    hold(9'b000010000, 1'b0, 30);
    hold(9'd0, 1'b0, 6);

    for (int f = 0; f < 6; f++) run_frame((f % 2 == 0) ? 9'b010000000 : 9'd0, 1'b0, 1'b0);
    hold(9'b010000000, 1'b0, 6);
    hold(9'd0, 1'b0, 6);

    hold(9'b100000001, 1'b0, 6);
    hold(9'b100000000, 1'b0, 6);
    hold(9'd0, 1'b0, 6);
    hold(9'b100000000, 1'b0, 6);
    hold(9'd0, 1'b0, 6);

    hold(9'b000000100, 1'b1, 6);
    hold(9'd0, 1'b1, 6);
    for (int f = 0; f < 6; f++) run_frame(9'b000000010, 1'b0, 1'b1);
    hold(9'd0, 1'b0, 6);

    hold(9'b000001000, 1'b0, 6);
    pressed = 9'b000100000;
    do_reset();
    hold(9'b000100000, 1'b0, 8);
    hold(9'd0, 1'b0, 6);
    hold(9'b000100000, 1'b0, 6);
    hold(9'd0, 1'b0, 5);

    m = 9'd0;
    for (int f = 0; f < 80; f++) begin
      sel = $urandom_range(0, 9);
      if (sel == 6)      m = 9'd0;
      else if (sel == 7) m = 9'd1 << $urandom_range(0, 8);
      else if (sel == 8) m = (9'd1 << $urandom_range(0, 8)) | (9'd1 << $urandom_range(0, 8));
      else if (sel == 9) m = 9'($urandom_range(0, 511));
      gd = ($urandom_range(0, 4) == 0);
      run_frame(m, gd, ($urandom_range(0, 2) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Upstream input stage for the tic-tac-toe game controller. Scans a 3x3 active-low matrix keypad, debounces it over whole scan frames and emits exactly one single-cycle `playerWrite` pulse with the pressed cell index on `playerInput` for each clean press/release of a single key. Its outputs drive the game controller's `playerWrite` / `playerInput` inputs directly. `gameIsDone` is fed back so that presses after the game ends are swallowed.

## Interface

Parameters:
- `SCAN_CYCLES`, default 16: cycles each column is driven. Must be ≥ 4.
- `DEBOUNCE_COUNT`, default 4: number of consecutive identical frames that counts as stable. Must be ≥ 2.

Ports:
- `ph1`  in  1  sole clock; all flops are rising-edge on `ph1`.
- `reset`  in  1  asynchronous, active-low reset.
- `row`  in  3  keypad row lines.
  - Active-low with external pull-ups; asynchronous to `ph1`.
  - `row[r]` low means a key in row r of the driven column is pressed.
- `col`  out  3  keypad column drive, one-hot active-low; `col[c]=0` drives column c.
- `gameIsDone`  in  1  game-over flag; while it is 1, no writes are generated.
- `playerWrite`  out  1  one-cycle write strobe.
- `playerInput`  out  4  cell index 0–8, where index = row*3 + col. It holds its value between writes.
- `keyHeld`  out  1  high while the FSM is in HELD.

## Operation

- **Synchronizer**
  - `row` passes through a 2-flop synchronizer before any use.
- **Scanner**
  - Scan counter runs 0..SCAN_CYCLES-1; column index runs 0..2. Both wrap.
  - `col = ~(3'b001 << colIdx)`.
  - On the last cycle of each column window (counter = SCAN_CYCLES-1):
    - Capture the inverted synchronized rows into `frame[r*3+c]`.
    - Advance the column.
  - Capturing column 2 completes a frame. The next cycle is `frameDone`.
  - Frame period is 3*SCAN_CYCLES cycles.
- **Frame code**, 4 bits:
  - 0–8 when exactly one bit of `frame` is set.
  - NONE = 4'hE when no bit is set.
  - MULTI = 4'hF when two or more bits are set.
- **Stability counter**
  - On each `frameDone`:
    - If code == prevCode, `stableCnt` increments, saturating at DEBOUNCE_COUNT.
    - Otherwise `stableCnt` = 1.
    - prevCode is then updated to code.
  - `stable` means `stableCnt` == DEBOUNCE_COUNT, evaluated after the update on that `frameDone`.
- **FSM**, evaluated only on `frameDone` cycles:
  - IDLE
    - stable NONE → READY.
  - READY
    - stable key k with gameIsDone=0 → HELD, and fire a write of k.
    - stable key k with gameIsDone=1 → HELD, no write.
    - stable MULTI → HELD, no write.
    - otherwise stay in READY.
  - HELD
    - stable NONE → READY.
    - anything else → stay in HELD; a changed key or MULTI never writes.
- **Write**
  - `playerWrite` is registered: high exactly one cycle, the cycle after the `frameDone` that took READY→HELD.
  - `playerInput` loads k in that same cycle.
- **Width rules**
  - Scan counter is $clog2(SCAN_CYCLES) bits.
  - `stableCnt` is $clog2(DEBOUNCE_COUNT+1) bits and never wraps.

## Timing

- **Reset values** (asynchronous, immediate on reset=0):
  - `col`=3'b110, `playerWrite`=0, `playerInput`=4'd0, `keyHeld`=0.
  - FSM=IDLE, counters=0, `stableCnt`=0, prevCode=NONE, synchronizer flops=3'b111.
- **Reset mid-operation** clears everything above. A key held across reset release therefore never writes: IDLE requires stable NONE first.
- **Press latency**: from a key being steady at the pins to `playerWrite` is at most (DEBOUNCE_COUNT+1)*3*SCAN_CYCLES + 1 cycles.
- **Release**: re-arming needs DEBOUNCE_COUNT consecutive NONE frames.
- **Debounce failure**: any single frame that differs restarts the count at 1.
- **`gameIsDone` sampling**: sampled only on the deciding `frameDone` cycle. Changes at other times have no effect.
- **Write spacing**: at most one write per press/release cycle. The minimum spacing between writes is 2*DEBOUNCE_COUNT frames.

## Test plan

All scenarios use the defaults: frame = 48 cycles, DEBOUNCE_COUNT=4.

- **Reset, keypad idle**
  - Stimulus: release reset with no key pressed.
  - Response: `col`=110 and cycles 110→101→011 every 16 cycles. After 4 frames the FSM is READY. `playerWrite` stays 0; `playerInput`=0.
- **Clean single press**
  - Stimulus: hold row1/col1 steady for 30 frames, then release.
  - Response: one `playerWrite` pulse with `playerInput`=4 after the 4th steady frame, and `keyHeld`=1. No further pulse. `keyHeld`=0 four frames after release.
- **Bouncy press**
  - Stimulus: key 7 toggles every frame for 6 frames, then stays steady.
  - Response: exactly one pulse with `playerInput`=7, 4 frames after it goes steady.
- **Multiple keys**
  - Stimulus: keys 0 and 8 pressed together and held; then key 0 released while key 8 is still held.
  - Response: no pulse; `keyHeld`=1. A pulse with 8 occurs only after a full release and a fresh press of 8.
- **Game over**
  - Stimulus: gameIsDone=1; press key 2.
  - Response: no pulse, `keyHeld`=1. `playerInput` keeps its previous value.
- **Reset interaction**
  - Stimulus: assert reset during HELD; then hold key 5 across reset release.
  - Response: outputs return to reset values immediately. Key 5 does not write until it is released and pressed again.
